// File: rtl/demux1x8_deser_pkg.sv
// Shared constants and types for the 1-to-8 deserializer and its mux8x1 counterpart.
// The slot-index type is shared with the mux-side benches so both ends agree on width.
package demux_pkg;

  localparam int DEMUX_N     = 8;
  localparam int DEMUX_SEL_W = 3;

  typedef logic [DEMUX_SEL_W-1:0] slot_idx_t;
  typedef logic [DEMUX_N-1:0]     word_t;

endpackage : demux_pkg

// File: rtl/demux1x8_deser_if.sv
// Serial-in / parallel-out bus of the deserializer.
// The master side drives the serial bit stream; the slave side is the deserializer.
interface demux1x8_deser_if;
  import demux_pkg::*;

  logic      in_valid;
  logic      in_bit;
  logic      auto;
  slot_idx_t sel;
  logic      commit;
  word_t     ot;
  logic      ot_valid;
  slot_idx_t slot;

  modport master (
    output in_valid, in_bit, auto, sel, commit,
    input  ot, ot_valid, slot
  );

  modport slave (
    input  in_valid, in_bit, auto, sel, commit,
    output ot, ot_valid, slot
  );

endinterface : demux1x8_deser_if

// File: rtl/demux1x8_deser_slot_ctr.sv
// Wrap-around slot counter with enable and synchronous clear.
// Clear wins over enable so a mode switch always lands on slot 0.
module slot_ctr
  import demux_pkg::*;
#(
  parameter int W = DEMUX_SEL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : slot_ctr

// File: rtl/demux1x8_deser.sv
// Sequential 1-to-8 demultiplexer: steers accepted serial bits into a shadow word and
// publishes it on a registered parallel output, auto-addressed by slot counter or manual via sel/commit.
module demux1x8_deser
  import demux_pkg::*;
#(
  parameter int N     = DEMUX_N,
  parameter int SEL_W = DEMUX_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  demux1x8_deser_if.slave   bus
);

  logic [N-1:0]     shadow_q;
  logic [N-1:0]     shadow_d;
  logic [N-1:0]     ot_q;
  logic [N-1:0]     ot_d;
  logic             ot_valid_q;
  logic             ot_valid_d;
  logic [N-1:0]     wr_en;
  logic [SEL_W-1:0] slot_cnt;
  logic [SEL_W-1:0] wr_idx;
  logic             publish;
  logic             ctr_clr;
  logic             ctr_en;

  // Manual mode parks the counter at 0 so returning to auto starts a fresh frame.
  assign ctr_clr = ~bus.auto;
  assign ctr_en  = bus.auto & bus.in_valid;

  slot_ctr #(
    .W (SEL_W)
  ) u_slot_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .cnt (slot_cnt)
  );

  assign wr_idx = bus.auto ? slot_cnt : bus.sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_wr_en
      assign wr_en[gi] = bus.in_valid & (wr_idx == SEL_W'(gi));
    end
  endgenerate

  // Publishing from shadow_d gives the same-cycle write bypass in both modes;
  // in auto mode at the last slot this is exactly {in_bit, shadow[N-2:0]}.
  assign publish = bus.auto ? (bus.in_valid & (slot_cnt == SEL_W'(N - 1)))
                            : bus.commit;

  always_comb begin
    shadow_d   = (shadow_q & ~wr_en) | (wr_en & {N{bus.in_bit}});
    ot_d       = ot_q;
    ot_valid_d = publish;
    if (publish) begin
      ot_d = shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      ot_q       <= '0;
      ot_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      ot_q       <= ot_d;
      ot_valid_q <= ot_valid_d;
    end
  end

  assign bus.ot       = ot_q;
  assign bus.ot_valid = ot_valid_q;
  assign bus.slot     = slot_cnt;

endmodule : demux1x8_deser

// File: tb/tb_demux1x8_deser.sv
// Self-checking bench for demux1x8_deser: expected words are queued when the publishing
// stimulus is driven and popped when ot_valid strobes.
module tb_demux1x8_deser;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  demux1x8_deser_if dif ();

  demux1x8_deser dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic b, input logic a,
                      input logic [2:0] s, input logic c);
    dif.in_valid = v;
    dif.in_bit   = b;
    dif.auto     = a;
    dif.sel      = s;
    dif.commit   = c;
    @(posedge clk);
    #1;
  endtask

  // Sends one auto-mode frame LSB first, optionally with idle cycles before bit gap_pos.
  task automatic run_auto_frame(input string name, input logic [7:0] word,
                                input int gap_pos, input int gap_len);
    logic [7:0] exp;
    logic       want;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
          checks++;
          if (dif.ot_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap_strobe: ot_valid=%b required 0", name, dif.ot_valid);
          end
        end
      end
      if (i == 7) exp_q.push_back(word);
      step(1'b1, word[i], 1'b1, 3'd0, 1'b0);
      want = (i == 7);
      checks++;
      if (dif.ot_valid !== want) begin
        errors++;
        $display("FAIL %s_strobe_bit%0d: ot_valid=%b required %b", name, i, dif.ot_valid, want);
      end
      if (((dif.ot_valid === 1'b1) || want) && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (dif.ot !== exp) begin
          errors++;
          $display("FAIL %s_word: ot=%h required %h", name, dif.ot, exp);
        end
      end
    end
    checks++;
    if (dif.slot !== 3'd0) begin
      errors++;
      $display("FAIL %s_slot_wrap: slot=%0d required 0", name, dif.slot);
    end
    $display("frame %s sent %h, ot=%h", name, word, dif.ot);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    rst = 1'b0;
    checks++;
    if (dif.ot !== 8'h00) begin
      errors++;
      $display("FAIL reset_ot: ot=%h required 00", dif.ot);
    end
    checks++;
    if (dif.ot_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: ot_valid=%b required 0", dif.ot_valid);
    end
    checks++;
    if (dif.slot !== 3'd0) begin
      errors++;
      $display("FAIL reset_slot: slot=%0d required 0", dif.slot);
    end
    $display("reset: ot=%h ot_valid=%b slot=%0d", dif.ot, dif.ot_valid, dif.slot);
  endtask

  task automatic test_auto_basic();
    run_auto_frame("auto_basic", 8'h0F, -1, 0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    checks++;
    if (dif.ot_valid !== 1'b0 || dif.ot !== 8'h0F) begin
      errors++;
      $display("FAIL auto_hold: ot=%h ot_valid=%b required 0f/0", dif.ot, dif.ot_valid);
    end
  endtask

  task automatic test_gap();
    run_auto_frame("gap", 8'h0F, 4, 3);
  endtask

  task automatic test_back_to_back();
    run_auto_frame("b2b_first", 8'h0F, -1, 0);
    run_auto_frame("b2b_second", 8'hA5, -1, 0);
  endtask

  task automatic test_manual();
    logic [7:0] exp;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 3'b101, 1'b0);
    checks++;
    if (dif.ot_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual_write_strobe: ot_valid=%b required 0", dif.ot_valid);
    end
    exp_q.push_back(8'h20);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (dif.ot_valid !== 1'b1 || dif.ot !== exp) begin
      errors++;
      $display("FAIL manual_commit: ot=%h ot_valid=%b required %h/1", dif.ot, dif.ot_valid, exp);
    end
    $display("manual commit: ot=%h", dif.ot);
    exp_q.push_back(8'h24);
    step(1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (dif.ot_valid !== 1'b1 || dif.ot !== exp) begin
      errors++;
      $display("FAIL manual_bypass: ot=%h ot_valid=%b required %h/1", dif.ot, dif.ot_valid, exp);
    end
    $display("manual bypass commit: ot=%h", dif.ot);
    exp_q.push_back(8'h24);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (dif.ot_valid !== 1'b1 || dif.ot !== exp) begin
      errors++;
      $display("FAIL manual_consecutive: ot=%h ot_valid=%b required %h/1", dif.ot, dif.ot_valid, exp);
    end
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checks++;
    if (dif.ot_valid !== 1'b0 || dif.ot !== 8'h24 || dif.slot !== 3'd0) begin
      errors++;
      $display("FAIL manual_idle: ot=%h ot_valid=%b slot=%0d required 24/0/0",
               dif.ot, dif.ot_valid, dif.slot);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    checks++;
    if (dif.slot !== 3'd4) begin
      errors++;
      $display("FAIL midrst_slot_before: slot=%0d required 4", dif.slot);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
    rst = 1'b0;
    checks++;
    if (dif.ot !== 8'h00 || dif.ot_valid !== 1'b0 || dif.slot !== 3'd0) begin
      errors++;
      $display("FAIL midrst_state: ot=%h ot_valid=%b slot=%0d required 00/0/0",
               dif.ot, dif.ot_valid, dif.slot);
    end
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    checks++;
    if (dif.ot_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after_strobe: ot_valid=%b required 0", dif.ot_valid);
    end
    run_auto_frame("after_reset", 8'h55, -1, 0);
  endtask

  task automatic test_mode_switch();
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    checks++;
    if (dif.slot !== 3'd3) begin
      errors++;
      $display("FAIL switch_slot_auto: slot=%0d required 3", dif.slot);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd6, 1'b0);
      checks++;
      if (dif.slot !== 3'd0 || dif.ot_valid !== 1'b0) begin
        errors++;
        $display("FAIL switch_manual_%0d: slot=%0d ot_valid=%b required 0/0",
                 i, dif.slot, dif.ot_valid);
      end
    end
    run_auto_frame("after_switch", 8'h3C, -1, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst          = 1'b1;
    dif.in_valid = 1'b0;
    dif.in_bit   = 1'b0;
    dif.auto     = 1'b1;
    dif.sel      = 3'd0;
    dif.commit   = 1'b0;

    test_reset();
    test_auto_basic();
    test_gap();
    test_back_to_back();
    test_manual();
    test_reset_mid_frame();
    test_mode_switch();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux1x8_deser

// File: doc/demux1x8_deser.md
# demux1x8_deser

Sequential 1-to-8 time-division demultiplexer: the receiving end of the 8:1 bit-select path built around `mux8x1`. It takes one bit per accepted cycle, steers it into slot `n` of an 8-bit shadow word, and publishes the completed word on a registered parallel output with a one-cycle valid strobe. Slot addressing is either automatic, via an internal slot counter, or explicit, via `sel` plus a `commit` strobe. It sits downstream of the mux/serializer and reconstructs the `it` vector that was presented there.

## Interface
- `N`, default 8: number of slots and output width. Fixed at 8 in this revision.
- `SEL_W`, default 3: slot-select width, equal to log2(N).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_bit` is accepted this cycle.
- `in_bit`  in  1  serial data bit.
- `auto`  in  1  1 selects automatic mode (internal slot counter); 0 selects manual mode (`sel` and `commit`).
- `sel`  in  SEL_W  slot index for manual mode; ignored when `auto`=1.
- `commit`  in  1  manual-mode publish strobe; ignored when `auto`=1.
- `ot`  out  N  registered parallel word.
- `ot_valid`  out  1  one-cycle strobe: `ot` was updated this cycle.
- `slot`  out  SEL_W  current auto-mode slot counter value, for debug.

## Operation
- State held:
  - `shadow[N-1:0]`
  - `slot` counter
  - `ot`
  - `ot_valid`
- Reset: `shadow`=0, `slot`=0, `ot`=8'h00, `ot_valid`=0.
- Auto mode (`auto`=1), on each cycle with `in_valid`=1:
  - `shadow[slot]` <= `in_bit`; `slot` <= `slot`+1, wrapping 7 -> 0.
  - When `slot`==7, the word is published: `ot` <= {`in_bit`, `shadow[6:0]`}, `ot_valid` <= 1.
  - Bit order is LSB first: the first accepted bit of a frame lands in `ot[0]`.
- `in_valid`=0: no state change. Gaps of any length inside a frame are allowed.
- Manual mode (`auto`=0):
  - `in_valid`=1 writes `shadow[sel]` <= `in_bit`.
  - `commit`=1 publishes: `ot` <= shadow with the same-cycle write already applied (write bypass), `ot_valid` <= 1.
  - `shadow` is not cleared on commit; slots that were not written keep their previous values.
- Mode switch: whenever `auto`=0, `slot` is held at 0. Switching back to auto always starts a fresh frame at slot 0. `shadow` contents are kept across the switch.
- `ot_valid` is 0 on every cycle that does not publish.
- `ot` holds its value between publishes.
- Reset mid-frame discards the partial frame. `ot` returns to 0 and no strobe is generated.

## Timing
- Auto mode latency: the 8th accepted bit is sampled at edge k. `ot` and `ot_valid` are visible after edge k (registered, one edge).
- Back-to-back frames: 8 accepted bits per publish, so `ot_valid` can assert at most every 8 accepted cycles. There are no dead cycles between frames.
- Manual mode: `commit` sampled at edge k makes `ot` and `ot_valid` visible after edge k.
- Consecutive manual `commit`s publish on consecutive cycles.
- `rst` has priority over every other input in the same cycle.
- No combinational path from any input to any output.

## Structure
- Shared package `demux_pkg` holds:
  - `DEMUX_N` = 8
  - `DEMUX_SEL_W` = 3
  - the slot-index type, shared with `mux8x1` benches
- One sub-module, `slot_ctr`: a 3-bit wrap counter with enable and synchronous clear, reused by the serializer side.
- Everything else lives in the top module, in a single always block for `shadow`/`ot`/`ot_valid`.

## Test plan
- Auto mode, `rst` then 8 accepted bits 1,1,1,1,0,0,0,0 -> `ot`=8'h0F and `ot_valid`=1 for exactly one cycle, after the 8th edge; `slot` back at 0.
- Auto mode, the same frame with `in_valid` low for 3 cycles between bits 4 and 5 -> identical `ot`=8'h0F, strobe delayed by 3 cycles.
- Back-to-back auto frames 8'h0F then 8'hA5, `in_valid` held high -> `ot_valid` after edges 8 and 16, `ot`=8'h0F then 8'hA5.
- Manual mode, after reset: write `sel`=3'b101 with bit 1, then `commit` -> `ot`=8'h20. Next, `sel`=3'b010 with bit 1 and `commit` in the same cycle -> `ot`=8'h24 (bypass).
- Auto mode, 4 bits of 1 then `rst` for one cycle, then frame 8'h55 -> `ot`=8'h55 with no stale bits; no strobe during or immediately after reset; `ot`=0 after reset.
- Switch `auto` from 1 to 0 mid-frame, then back to 1 -> `slot`=0 while `auto`=0; the next 8 bits 8'h3C publish `ot`=8'h3C.
